// File: rtl/rx_pipeline_sequencer.sv
// Receive-path sequencer: low-pass -> decimated band-pass -> correlator bank sweep.
// Optional watchdog on the *_WAIT states is enabled by defining RX_SEQ_WATCHDOG_EN.
module rx_pipeline_sequencer #(
    parameter int DECIM  = 4,
    parameter int N_CORR = 16,
    parameter int SEL_W  = 4
`ifdef RX_SEQ_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES = 64
`endif
) (
    input  logic             crx_clk,
    input  logic             rrx_rst,
    input  logic             erx_en,
    input  logic             isample_valid,
    input  logic             ilp_done,
    input  logic             ibp_done,
    input  logic             icorr_done,
    input  logic             iclr_flags,
    output logic             olp_start,
    output logic             obp_start,
    output logic             ocorr_start,
    output logic [SEL_W-1:0] ocorr_sel,
    output logic [1:0]       odecim_phase,
    output logic             osweep_done,
    output logic             obusy,
    output logic             ooverrun,
    output logic             otimeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LP_WAIT,
        S_BP_WAIT,
        S_CORR_START,
        S_CORR_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [1:0]       phase_q, phase_d;
    logic             lp_start_q, lp_start_d;
    logic             bp_start_q, bp_start_d;
    logic             corr_start_q, corr_start_d;
    logic             sweep_q, sweep_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             timeout_set;

`ifdef RX_SEQ_WATCHDOG_EN
    logic [15:0] wdog_q, wdog_d;
    logic        timeout_q, timeout_d;
    logic        in_wait;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        phase_d     = phase_q;
        sweep_d     = 1'b0;
        timeout_set = 1'b0;
        // A strobe while busy (even on the cycle we fall back to IDLE) is dropped.
        overrun_d   = (overrun_q & ~iclr_flags) | (isample_valid & (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (isample_valid) state_d = S_LP_WAIT;
            end
            S_LP_WAIT: begin
                if (ilp_done) begin
                    phase_d = (phase_q == 2'(DECIM - 1)) ? 2'd0 : phase_q + 2'd1;
                    state_d = (phase_q == 2'd0) ? S_BP_WAIT : S_IDLE;
                end
            end
            S_BP_WAIT: begin
                if (ibp_done) begin
                    sel_d   = '0;
                    state_d = S_CORR_START;
                end
            end
            S_CORR_START: begin
                state_d = S_CORR_WAIT;
            end
            S_CORR_WAIT: begin
                if (icorr_done) begin
                    if (sel_q == SEL_W'(N_CORR - 1)) begin
                        sweep_d = 1'b1;
                        sel_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        sel_d   = sel_q + 1'b1;
                        state_d = S_CORR_START;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef RX_SEQ_WATCHDOG_EN
        in_wait = (state_q == S_LP_WAIT) || (state_q == S_BP_WAIT) || (state_q == S_CORR_WAIT);
        if (in_wait && (state_d == state_q) && (wdog_q == 16'(WDOG_CYCLES - 1))) begin
            timeout_set = 1'b1;
            sel_d       = '0;
            state_d     = S_IDLE;
        end
`endif

        if (!erx_en) begin
            state_d     = S_IDLE;
            sel_d       = '0;
            phase_d     = phase_q;
            sweep_d     = 1'b0;
            timeout_set = 1'b0;
        end

        // Start pulses coincide with the first cycle of the state that consumes the result.
        lp_start_d   = (state_d == S_LP_WAIT) && (state_q != S_LP_WAIT);
        bp_start_d   = (state_d == S_BP_WAIT) && (state_q != S_BP_WAIT);
        corr_start_d = (state_d == S_CORR_START);
        busy_d       = (state_d != S_IDLE);

`ifdef RX_SEQ_WATCHDOG_EN
        timeout_d = (timeout_q & ~iclr_flags) | timeout_set;
        if (state_d != state_q) wdog_d = '0;
        else if (in_wait)       wdog_d = wdog_q + 16'd1;
        else                    wdog_d = '0;
`endif
    end

    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            phase_q      <= '0;
            lp_start_q   <= 1'b0;
            bp_start_q   <= 1'b0;
            corr_start_q <= 1'b0;
            sweep_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            phase_q      <= phase_d;
            lp_start_q   <= lp_start_d;
            bp_start_q   <= bp_start_d;
            corr_start_q <= corr_start_d;
            sweep_q      <= sweep_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef RX_SEQ_WATCHDOG_EN
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end
    assign otimeout = timeout_q;
`else
    assign otimeout = 1'b0;
`endif

    assign olp_start    = lp_start_q;
    assign obp_start    = bp_start_q;
    assign ocorr_start  = corr_start_q;
    assign ocorr_sel    = sel_q;
    assign odecim_phase = phase_q;
    assign osweep_done  = sweep_q;
    assign obusy        = busy_q;
    assign ooverrun     = overrun_q;

endmodule

// File: tb/tb_rx_pipeline_sequencer.sv
// Scoreboard bench for rx_pipeline_sequencer: expected start/sweep events are queued
// by the stimulus and popped by an independent monitor; done pulses come from a responder.
module tb_rx_pipeline_sequencer;

    localparam int K_LP = 0, K_BP = 1, K_CORR = 2, K_SWEEP = 3;

    logic       crx_clk, rrx_rst, erx_en, isample_valid;
    logic       ilp_done, ibp_done, icorr_done, iclr_flags;
    logic       olp_start, obp_start, ocorr_start, osweep_done, obusy, ooverrun, otimeout;
    logic [3:0] ocorr_sel;
    logic [1:0] odecim_phase;

    typedef struct {
        int kind;
        int sel;
    } ev_t;
    ev_t exp_q[$];

    int  n_pass = 0;
    int  n_total = 0;
    bit  lp_resp_en = 1, bp_resp_en = 1, corr_resp_en = 1;

    rx_pipeline_sequencer dut (
        .crx_clk      (crx_clk),
        .rrx_rst      (rrx_rst),
        .erx_en       (erx_en),
        .isample_valid(isample_valid),
        .ilp_done     (ilp_done),
        .ibp_done     (ibp_done),
        .icorr_done   (icorr_done),
        .iclr_flags   (iclr_flags),
        .olp_start    (olp_start),
        .obp_start    (obp_start),
        .ocorr_start  (ocorr_start),
        .ocorr_sel    (ocorr_sel),
        .odecim_phase (odecim_phase),
        .osweep_done  (osweep_done),
        .obusy        (obusy),
        .ooverrun     (ooverrun),
        .otimeout     (otimeout)
    );

    initial begin
        crx_clk = 1'b0;
        forever #5 crx_clk = ~crx_clk;
    end

    task automatic chk(input string nm, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    task automatic push(input int k, input int s);
        ev_t e;
        e.kind = k;
        e.sel  = s;
        exp_q.push_back(e);
    endtask

    // lp, bp, then banks 0..n_banks-1, and the sweep pulse if the sweep completes
    task automatic push_run(input int n_banks, input bit with_sweep);
        push(K_LP, 0);
        push(K_BP, 0);
        for (int i = 0; i < n_banks; i++) push(K_CORR, i);
        if (with_sweep) push(K_SWEEP, 0);
    endtask

    task automatic mon(input int k, input int s);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL event_unexpected: got kind %0d sel %0d, required no event", k, s);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.sel == s) n_pass++;
            else $display("FAIL event_order: got kind %0d sel %0d, required kind %0d sel %0d",
                          k, s, e.kind, e.sel);
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    initial begin
        forever begin
            @(negedge crx_clk);
            if (!rrx_rst) begin
                if (olp_start)   mon(K_LP, 0);
                if (obp_start)   mon(K_BP, 0);
                if (ocorr_start) mon(K_CORR, int'(ocorr_sel));
                if (osweep_done) mon(K_SWEEP, 0);
            end
        end
    end

    // Responder: each start is answered by its done pulse three clocks later.
    initial begin
        int lp_cnt = 0, bp_cnt = 0, corr_cnt = 0;
        ilp_done = 0; ibp_done = 0; icorr_done = 0;
        forever begin
            @(negedge crx_clk);
            ilp_done = 0; ibp_done = 0; icorr_done = 0;
            if (lp_cnt > 0)   begin lp_cnt--;   if (lp_cnt == 0)   ilp_done = 1;   end
            if (bp_cnt > 0)   begin bp_cnt--;   if (bp_cnt == 0)   ibp_done = 1;   end
            if (corr_cnt > 0) begin corr_cnt--; if (corr_cnt == 0) icorr_done = 1; end
            if (olp_start && lp_resp_en)     lp_cnt = 3;
            if (obp_start && bp_resp_en)     bp_cnt = 3;
            if (ocorr_start && corr_resp_en) corr_cnt = 3;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    function automatic bit ev_now(input int k, input int s);
        case (k)
            K_LP:    return olp_start;
            K_BP:    return obp_start;
            K_CORR:  return ocorr_start && (int'(ocorr_sel) == s);
            default: return osweep_done;
        endcase
    endfunction

    task automatic wait_ev(input int k, input int s, input int budget, input string nm);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge crx_clk);
            hit = ev_now(k, s);
        end
        if (!hit) begin
            n_total++;
            $display("FAIL %s: event not seen in %0d cycles, required seen", nm, budget);
        end
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int i = 0;
        while (obusy && i < budget) begin
            @(negedge crx_clk);
            i++;
        end
        chk(nm, int'(obusy), 0);
    endtask

    task automatic strobe();
        @(negedge crx_clk) isample_valid = 1;
        @(negedge crx_clk) isample_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge crx_clk) rrx_rst = 1;
        @(negedge crx_clk) rrx_rst = 0;
    endtask

    initial begin
        int exp_ph[4];
        int cyc;
        exp_ph[0] = 1; exp_ph[1] = 2; exp_ph[2] = 3; exp_ph[3] = 0;
        rrx_rst = 1; erx_en = 1; isample_valid = 0; iclr_flags = 0;
        repeat (3) @(negedge crx_clk);
        rrx_rst = 0;
        chk("reset_busy", int'(obusy), 0);
        chk("reset_phase", int'(odecim_phase), 0);
        chk("reset_sel", int'(ocorr_sel), 0);
        chk("reset_overrun", int'(ooverrun), 0);

        // Full sweep from phase 0
        push_run(16, 1);
        strobe();
        chk("lp_start_latency", int'(olp_start), 1);
        wait_idle(200, "sweep_idle");
        chk("sweep_phase", int'(odecim_phase), 1);
        chk("sweep_queue_empty", exp_q.size(), 0);

        // Four strobes 128 clocks apart: band-pass only on the first
        do_reset();
        for (int s = 0; s < 4; s++) begin
            if (s == 0) push_run(16, 1);
            else push(K_LP, 0);
            strobe();
            repeat (126) @(negedge crx_clk);
            chk("decim_busy", int'(obusy), 0);
            chk("decim_phase", int'(odecim_phase), exp_ph[s]);
        end
        chk("decim_queue_empty", exp_q.size(), 0);

        // Overrun during CORR_WAIT at bank 5; sweep must still complete
        push_run(16, 1);
        strobe();
        wait_ev(K_CORR, 5, 100, "wait_corr5");
        @(negedge crx_clk) isample_valid = 1;
        @(negedge crx_clk) isample_valid = 0;
        chk("overrun_set", int'(ooverrun), 1);
        wait_idle(200, "overrun_idle");
        chk("overrun_sticky", int'(ooverrun), 1);
        chk("overrun_queue_empty", exp_q.size(), 0);
        @(negedge crx_clk) iclr_flags = 1;
        @(negedge crx_clk) iclr_flags = 0;
        chk("overrun_clear", int'(ooverrun), 0);

        // Enable dropped in CORR_WAIT at bank 7
        do_reset();
        push_run(8, 0);
        strobe();
        wait_ev(K_CORR, 7, 100, "wait_corr7");
        @(negedge crx_clk) erx_en = 0;
        @(negedge crx_clk);
        chk("abort_busy", int'(obusy), 0);
        chk("abort_sel", int'(ocorr_sel), 0);
        chk("abort_phase", int'(odecim_phase), 1);
        repeat (10) @(negedge crx_clk);
        chk("abort_phase_held", int'(odecim_phase), 1);
        chk("abort_queue_empty", exp_q.size(), 0);
        erx_en = 1;

        // Band-pass never completes
        do_reset();
        bp_resp_en = 0;
        push(K_LP, 0);
        push(K_BP, 0);
        strobe();
        wait_ev(K_BP, 0, 20, "wait_bp");
`ifdef RX_SEQ_WATCHDOG_EN
        cyc = 0;
        while (obusy && cyc < 200) begin
            @(negedge crx_clk);
            cyc++;
        end
        chk("wdog_cycles", cyc, 64);
        chk("wdog_timeout", int'(otimeout), 1);
        chk("wdog_busy", int'(obusy), 0);
`else
        cyc = 0;
        repeat (100) @(negedge crx_clk);
        chk("nowdog_still_busy", int'(obusy), 1);
        chk("nowdog_timeout", int'(otimeout), 0);
        @(negedge crx_clk) erx_en = 0;
        @(negedge crx_clk) erx_en = 1;
        chk("nowdog_recover", int'(obusy), 0);
`endif
        bp_resp_en = 1;
        push(K_LP, 0);
        strobe();
        wait_idle(50, "after_bp_idle");
        chk("after_bp_phase", int'(odecim_phase), 2);
        chk("after_bp_queue_empty", exp_q.size(), 0);
`ifdef RX_SEQ_WATCHDOG_EN
        chk("timeout_sticky", int'(otimeout), 1);
`endif
        @(negedge crx_clk) iclr_flags = 1;
        @(negedge crx_clk) iclr_flags = 0;
        chk("timeout_clear", int'(otimeout), 0);

        // Asynchronous reset in the middle of a sweep
        do_reset();
        push_run(4, 0);
        strobe();
        wait_ev(K_CORR, 3, 100, "wait_corr3");
        #2 rrx_rst = 1;
        #1;
        chk("arst_lp_start", int'(olp_start), 0);
        chk("arst_corr_start", int'(ocorr_start), 0);
        chk("arst_sel", int'(ocorr_sel), 0);
        chk("arst_phase", int'(odecim_phase), 0);
        chk("arst_busy", int'(obusy), 0);
        chk("arst_overrun", int'(ooverrun), 0);
        chk("arst_queue_empty", exp_q.size(), 0);
        @(negedge crx_clk) rrx_rst = 0;
        repeat (10) @(negedge crx_clk);
        chk("final_busy", int'(obusy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
